// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the data-memory interface.
// Requests enter an in-order queue. Each one is served from an internal
// word-addressed SRAM after LATENCY cycles. Responses are returned through a
// valid/ready channel.
// Optional build macro DMEM_ALIGN_CHECK_EN adds resp_err_o. With it defined,
// an access whose byte address is not word-aligned does not touch memory and
// returns 32'hDEADBEEF.
//
// state  | meaning
// IDLE   | queue empty, nothing in flight
// WAIT   | counting down the access latency for the head entry
// RESP   | head entry executed, response held until resp_ready_i
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_we_o,
  output logic [31:0] resp_rdata_o
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        resp_err_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = 3;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0]           mem_q [DEPTH];

  logic                  q_we_q    [QDEPTH];
  logic [DEPTH_LOG2-1:0] q_idx_q   [QDEPTH];
  logic [31:0]           q_wdata_q [QDEPTH];
`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0]            q_lo_q    [QDEPTH];
  logic                  resp_err_q, resp_err_d;
`endif

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       lat_q, lat_d;
  logic             resp_we_q, resp_we_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;

  logic                  push, pop, exec, mis;
  logic                  head_we;
  logic [DEPTH_LOG2-1:0] head_idx;
  logic [31:0]           head_wdata;

  // Address bits outside the word index are deliberately ignored.
`ifdef DMEM_ALIGN_CHECK_EN
  logic unused_addr;
  assign unused_addr = ^req_addr_i[31:DEPTH_LOG2+2];
`else
  logic unused_addr;
  assign unused_addr = ^{req_addr_i[31:DEPTH_LOG2+2], req_addr_i[1:0]};
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready comes from the registered count only, so a pop cannot free a slot
  // for a push in the same cycle.
  assign req_ready_o  = (count_q < CNT_W'(QDEPTH));
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_we_o    = resp_we_q;
  assign resp_rdata_o = resp_rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign resp_err_o   = resp_err_q;
`endif

  assign push = req_valid_i && req_ready_o;
  assign pop  = (state_q == S_RESP) && resp_ready_i;
  assign exec = (state_q == S_WAIT) && (lat_q == 4'd0);

  assign head_we    = q_we_q[rd_ptr_q];
  assign head_idx   = q_idx_q[rd_ptr_q];
  assign head_wdata = q_wdata_q[rd_ptr_q];
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = (q_lo_q[rd_ptr_q] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // Queue pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Sequencing FSM. IDLE starts the countdown on the accept edge itself, so
  // resp_valid rises exactly LATENCY cycles after the accept.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0 || push) begin
          state_d = S_WAIT;
          lat_d   = LAT_INIT;
        end
      end
      S_WAIT: begin
        if (lat_q == 4'd0) state_d = S_RESP;
        else               lat_d   = lat_q - 4'd1;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          if (count_d != '0) begin
            state_d = S_WAIT;
            lat_d   = LAT_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response payload is captured when the head entry executes.
  always_comb begin
    resp_we_d    = resp_we_q;
    resp_rdata_d = resp_rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
    resp_err_d   = resp_err_q;
`endif
    if (exec) begin
      resp_we_d = head_we;
      if (mis)          resp_rdata_d = 32'hDEADBEEF;
      else if (head_we) resp_rdata_d = head_wdata;
      else              resp_rdata_d = mem_q[head_idx];
`ifdef DMEM_ALIGN_CHECK_EN
      resp_err_d = mis;
`endif
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      lat_q        <= '0;
      resp_we_q    <= 1'b0;
      resp_rdata_q <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      lat_q        <= lat_d;
      resp_we_q    <= resp_we_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef DMEM_ALIGN_CHECK_EN
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  // Queue entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_we_q[wr_ptr_q]    <= req_we_i;
      q_idx_q[wr_ptr_q]   <= req_addr_i[DEPTH_LOG2+1:2];
      q_wdata_q[wr_ptr_q] <= req_wdata_i;
`ifdef DMEM_ALIGN_CHECK_EN
      q_lo_q[wr_ptr_q]    <= req_addr_i[1:0];
`endif
    end
  end

  // SRAM write. It is not reset, so a store that has already executed survives reset.
  always_ff @(posedge clk) begin
    if (exec && head_we && !mis) mem_q[head_idx] <= head_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters
// (DEPTH_LOG2=8, LATENCY=2, QDEPTH=2).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_we;
  logic [31:0] resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        resp_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_we_o    (resp_we),
    .resp_rdata_o (resp_rdata)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .resp_err_o   (resp_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input string tag);
    int i;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    i = 0;
    while (!req_ready && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    chk({tag, " accept"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic get_resp(input string tag, input logic we, input logic [31:0] data);
    int cyc;
    wait_valid(cyc);
    chk({tag, " valid"}, resp_valid, 1);
    chk({tag, " we"}, resp_we, we);
    chk({tag, " rdata"}, resp_rdata, data);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    #1;
    chk("rst valid", resp_valid, 0);
    chk("rst rdata", resp_rdata, 0);
    chk("rst ready", req_ready, 1);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store then load with exact latency.
    send(1'b1, 32'h10, 32'hCAFEF00D, "st10");
    wait_valid(cyc);
    chk("st10 latency", cyc, 2);
    get_resp("st10", 1'b1, 32'hCAFEF00D);
    chk("st10 valid drop", resp_valid, 0);
    send(1'b0, 32'h10, 32'h0, "ld10");
    wait_valid(cyc);
    chk("ld10 latency", cyc, 2);
    get_resp("ld10", 1'b0, 32'hCAFEF00D);

    // Queue full with resp_ready low.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = '0;
    chk("qA ready", req_ready, 1);
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h48; req_wdata = 32'h0BADF00D;
    chk("qB ready", req_ready, 1);
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 32'h48; req_wdata = '0;
    chk("qC full ready", req_ready, 0);
    @(posedge clk); #1;
    chk("qC full ready2", req_ready, 0);
    chk("qA valid", resp_valid, 1);
    chk("qA rdata", resp_rdata, 32'hCAFEF00D);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("qC ready rise", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("qC accepted", req_ready, 0);
    get_resp("qB", 1'b1, 32'h0BADF00D);
    get_resp("qC", 1'b0, 32'h0BADF00D);
    chk("q drained valid", resp_valid, 0);
    chk("q drained ready", req_ready, 1);

    // Backpressure: response held stable.
    send(1'b1, 32'h20, 32'h12345678, "st20");
    get_resp("st20", 1'b1, 32'h12345678);
    send(1'b0, 32'h20, 32'h0, "ld20");
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", resp_valid, 1);
      chk("bp rdata", resp_rdata, 32'h12345678);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp pop", resp_valid, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("bp single pop", resp_valid, 0);
    chk("bp empty ready", req_ready, 1);

    // Aliasing modulo 1 KiB.
    send(1'b1, 32'h400, 32'hA5A5A5A5, "st400");
    get_resp("st400", 1'b1, 32'hA5A5A5A5);
    send(1'b0, 32'h0, 32'h0, "ld0");
    get_resp("alias ld0", 1'b0, 32'hA5A5A5A5);

    // Reset mid-operation, while the store to 0x30 is still waiting.
    send(1'b1, 32'h30, 32'h11111111, "st30");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h34; req_wdata = 32'h22222222;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst valid", resp_valid, 0);
    chk("midrst rdata", resp_rdata, 0);
    chk("midrst we", resp_we, 0);
    chk("midrst ready", req_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    chk("inrst ready", req_ready, 1);
    chk("inrst valid", resp_valid, 0);
    req_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no resp after rst", resp_valid, 0);
    send(1'b0, 32'h30, 32'h0, "ld30");
    get_resp("ld30 after rst", 1'b0, 32'h0);
    send(1'b0, 32'h34, 32'h0, "ld34");
    get_resp("ld34 after rst", 1'b0, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
    send(1'b1, 32'h31, 32'h33333333, "st31");
    wait_valid(cyc);
    chk("mis latency", cyc, 2);
    chk("mis err", resp_err, 1);
    chk("mis rdata", resp_rdata, 32'hDEADBEEF);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    send(1'b0, 32'h30, 32'h0, "ld30b");
    get_resp("ld30 after mis", 1'b0, 32'h0);
    chk("aligned err", resp_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
